// File: rtl/alu_rs_if.sv
// -----------------------------------------------------------------------------
// alu_rs_if
// Bundles the signals around the ALU reservation station:
//   dispatch request : dec_valid, dec_op, dec_val1/2, dec_qj/qk(_valid), dec_id
//   result buses     : alu_ready/res/id, lsb_ready/res/id
//   issue to the ALU : rs_ready, rs_op, rs_val1/2, rs_id
//   status           : rs_full
// master = reservation station side, slave = surrounding pipeline / ALU side.
// -----------------------------------------------------------------------------
interface alu_rs_if #(
    parameter int XLEN           = 32,
    parameter int ALU_OP_WIDTH   = 4,
    parameter int ROB_SIZE_WIDTH = 4
);
    logic                      dec_valid;
    logic [ALU_OP_WIDTH-1:0]   dec_op;
    logic [XLEN-1:0]           dec_val1;
    logic [XLEN-1:0]           dec_val2;
    logic                      dec_qj_valid;
    logic                      dec_qk_valid;
    logic [ROB_SIZE_WIDTH-1:0] dec_qj;
    logic [ROB_SIZE_WIDTH-1:0] dec_qk;
    logic [ROB_SIZE_WIDTH-1:0] dec_id;

    logic                      alu_ready;
    logic [XLEN-1:0]           alu_res;
    logic [ROB_SIZE_WIDTH-1:0] alu_id;
    logic                      lsb_ready;
    logic [XLEN-1:0]           lsb_res;
    logic [ROB_SIZE_WIDTH-1:0] lsb_id;

    logic                      rs_full;
    logic                      rs_ready;
    logic [ALU_OP_WIDTH-1:0]   rs_op;
    logic [XLEN-1:0]           rs_val1;
    logic [XLEN-1:0]           rs_val2;
    logic [ROB_SIZE_WIDTH-1:0] rs_id;

    modport master (
        input  dec_valid, dec_op, dec_val1, dec_val2, dec_qj_valid, dec_qk_valid,
               dec_qj, dec_qk, dec_id,
               alu_ready, alu_res, alu_id, lsb_ready, lsb_res, lsb_id,
        output rs_full, rs_ready, rs_op, rs_val1, rs_val2, rs_id
    );

    modport slave (
        output dec_valid, dec_op, dec_val1, dec_val2, dec_qj_valid, dec_qk_valid,
               dec_qj, dec_qk, dec_id,
               alu_ready, alu_res, alu_id, lsb_ready, lsb_res, lsb_id,
        input  rs_full, rs_ready, rs_op, rs_val1, rs_val2, rs_id
    );
endinterface

// File: rtl/alu_rs.sv
// -----------------------------------------------------------------------------
// alu_rs
// Reservation station in front of the integer ALU. Holds dispatched ALU ops
// until both operands are known, snoops the ALU and LSB result buses for
// pending operands, and issues the lowest-index ready entry once per cycle.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   flush  : synchronous misprediction flush, empties the station
//   bus    : alu_rs_if.master (dispatch in, result buses in, issue out, rs_full)
// -----------------------------------------------------------------------------
module alu_rs #(
    parameter int RS_SIZE        = 8,
    parameter int RS_SIZE_WIDTH  = 3,
    parameter int XLEN           = 32,
    parameter int ALU_OP_WIDTH   = 4,
    parameter int ROB_SIZE_WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    alu_rs_if.master  bus
);
    localparam int CW = RS_SIZE_WIDTH + 1;

    // Entry payload; only meaningful while the matching busy bit is set.
    logic [ALU_OP_WIDTH-1:0]   op_q   [RS_SIZE];
    logic [XLEN-1:0]           val1_q [RS_SIZE];
    logic [XLEN-1:0]           val2_q [RS_SIZE];
    logic                      qjv_q  [RS_SIZE];
    logic                      qkv_q  [RS_SIZE];
    logic [ROB_SIZE_WIDTH-1:0] qj_q   [RS_SIZE];
    logic [ROB_SIZE_WIDTH-1:0] qk_q   [RS_SIZE];
    logic [ROB_SIZE_WIDTH-1:0] id_q   [RS_SIZE];

    logic [RS_SIZE-1:0]        busy_q, busy_d;
    logic [CW-1:0]             count_q, count_d;

    logic                      rs_ready_q;
    logic [ALU_OP_WIDTH-1:0]   rs_op_q;
    logic [XLEN-1:0]           rs_val1_q;
    logic [XLEN-1:0]           rs_val2_q;
    logic [ROB_SIZE_WIDTH-1:0] rs_id_q;

    logic                      free_found, iss_found, disp_ok, rs_full;
    logic [RS_SIZE_WIDTH-1:0]  free_idx, iss_idx;

    // Operand snoop: the ALU bus has priority over the LSB bus when both
    // carry the tag an operand is waiting on.
    function automatic logic [XLEN-1:0] snoop_val(input logic pend,
                                                  input logic [ROB_SIZE_WIDTH-1:0] tag,
                                                  input logic [XLEN-1:0] cur);
        if (pend && bus.alu_ready && tag == bus.alu_id)
            return bus.alu_res;
        else if (pend && bus.lsb_ready && tag == bus.lsb_id)
            return bus.lsb_res;
        return cur;
    endfunction

    function automatic logic snoop_pend(input logic pend,
                                        input logic [ROB_SIZE_WIDTH-1:0] tag);
        return pend && !(bus.alu_ready && tag == bus.alu_id)
                    && !(bus.lsb_ready && tag == bus.lsb_id);
    endfunction

    // Lowest-index free slot and lowest-index ready slot; scanning downward
    // lets the last hit be the lowest index.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        iss_found  = 1'b0;
        iss_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = RS_SIZE_WIDTH'(i);
            end
            if (busy_q[i] && !qjv_q[i] && !qkv_q[i]) begin
                iss_found = 1'b1;
                iss_idx   = RS_SIZE_WIDTH'(i);
            end
        end
    end

    assign rs_full = (count_q == CW'(RS_SIZE));
    assign disp_ok = bus.dec_valid && !rs_full && free_found;

    // Free slot is never busy and issue slot always is, so the two updates
    // never touch the same bit; an entry freed by issue waits a cycle.
    always_comb begin
        busy_d = busy_q;
        if (iss_found) busy_d[iss_idx]  = 1'b0;
        if (disp_ok)   busy_d[free_idx] = 1'b1;
        count_d = count_q + CW'(disp_ok) - CW'(iss_found);
    end

    // Entry payload: dispatch write with same-cycle forwarding, else wakeup.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            if (disp_ok && free_idx == RS_SIZE_WIDTH'(i)) begin
                op_q[i]   <= bus.dec_op;
                id_q[i]   <= bus.dec_id;
                qj_q[i]   <= bus.dec_qj;
                qk_q[i]   <= bus.dec_qk;
                val1_q[i] <= snoop_val(bus.dec_qj_valid, bus.dec_qj, bus.dec_val1);
                val2_q[i] <= snoop_val(bus.dec_qk_valid, bus.dec_qk, bus.dec_val2);
                qjv_q[i]  <= snoop_pend(bus.dec_qj_valid, bus.dec_qj);
                qkv_q[i]  <= snoop_pend(bus.dec_qk_valid, bus.dec_qk);
            end else begin
                val1_q[i] <= snoop_val(qjv_q[i], qj_q[i], val1_q[i]);
                val2_q[i] <= snoop_val(qkv_q[i], qk_q[i], val2_q[i]);
                qjv_q[i]  <= snoop_pend(qjv_q[i], qj_q[i]);
                qkv_q[i]  <= snoop_pend(qkv_q[i], qk_q[i]);
            end
        end
    end

    // Occupancy and the registered issue port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            count_q    <= '0;
            rs_ready_q <= 1'b0;
            rs_op_q    <= '0;
            rs_val1_q  <= '0;
            rs_val2_q  <= '0;
            rs_id_q    <= '0;
        end else if (flush) begin
            busy_q     <= '0;
            count_q    <= '0;
            rs_ready_q <= 1'b0;
            rs_op_q    <= '0;
            rs_val1_q  <= '0;
            rs_val2_q  <= '0;
            rs_id_q    <= '0;
        end else begin
            busy_q     <= busy_d;
            count_q    <= count_d;
            rs_ready_q <= iss_found;
            rs_op_q    <= iss_found ? op_q[iss_idx]   : '0;
            rs_val1_q  <= iss_found ? val1_q[iss_idx] : '0;
            rs_val2_q  <= iss_found ? val2_q[iss_idx] : '0;
            rs_id_q    <= iss_found ? id_q[iss_idx]   : '0;
        end
    end

    assign bus.rs_full  = rs_full;
    assign bus.rs_ready = rs_ready_q;
    assign bus.rs_op    = rs_op_q;
    assign bus.rs_val1  = rs_val1_q;
    assign bus.rs_val2  = rs_val2_q;
    assign bus.rs_id    = rs_id_q;
endmodule
